// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, classes,
// state encoding and the operand-2 select encodings.
package control_fsm_pkg;

  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned ALU_SEL_W = 2;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DATA_W    = 32;

  localparam logic [OPCODE_W-1:0] OP_R_ALU = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_I_ALU = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_STORE = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_IMM    = 2'b00;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_OFFSET = 2'b01;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_RD2    = 2'b10;

  typedef enum logic [2:0] {
    CLS_R_ALU   = 3'd0,
    CLS_I_ALU   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_e;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Operand-2 source chosen in EXEC, held through MEM and WB.
  function automatic logic [ALU_SEL_W-1:0] exec_alu_select(op_class_e cls);
    case (cls)
      CLS_I_ALU, CLS_JUMP:  exec_alu_select = ALU_SEL_IMM;
      CLS_LOAD, CLS_STORE:  exec_alu_select = ALU_SEL_OFFSET;
      default:              exec_alu_select = ALU_SEL_RD2;
    endcase
  endfunction

  // Datapath operand-2 mux driven by alu_select.
  function automatic logic [DATA_W-1:0] operand2_mux(logic [ALU_SEL_W-1:0] sel,
                                                     logic [DATA_W-1:0] imm,
                                                     logic [DATA_W-1:0] offset,
                                                     logic [DATA_W-1:0] rd2);
    case (sel)
      ALU_SEL_IMM:    operand2_mux = imm;
      ALU_SEL_OFFSET: operand2_mux = offset;
      default:        operand2_mux = rd2;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_op_class_decode.sv
// Combinational opcode-to-class decode; anything not listed is illegal.
module op_class_decode
  import control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_e  op_class_c
);

  always_comb begin
    op_class_c = CLS_ILLEGAL;
    case (opcode)
      OP_R_ALU: op_class_c = CLS_R_ALU;
      OP_I_ALU: op_class_c = CLS_I_ALU;
      OP_LOAD:  op_class_c = CLS_LOAD;
      OP_STORE: op_class_c = CLS_STORE;
      OP_BEQ:   op_class_c = CLS_BEQ;
      OP_JUMP:  op_class_c = CLS_JUMP;
      OP_HALT:  op_class_c = CLS_HALT;
      default:  op_class_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM. Strobes are decoded from state and
// gated by rst so that reset and reset release take effect between edges.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero_flag,
  output logic [1:0] alu_select,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_load,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal
);

  state_e    state_q, state_d;
  op_class_e class_q, class_d, dec_class;
  logic      illegal_q, illegal_d;

  logic [ALU_SEL_W-1:0] alu_sel_c;
  logic mem_read_c, mem_write_c, ir_load_c, pc_write_c;
  logic reg_write_c, mem_to_reg_c, halted_c;

  op_class_decode u_decode (
    .opcode     (opcode),
    .op_class_c (dec_class)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_R_ALU;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    illegal_d    = illegal_q;
    alu_sel_c    = ALU_SEL_RD2;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_load_c    = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    halted_c     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_load_c  = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        case (dec_class)
          CLS_HALT: state_d = ST_HALT;
          CLS_ILLEGAL: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_sel_c = exec_alu_select(class_q);
        case (class_q)
          CLS_R_ALU, CLS_I_ALU: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BEQ: begin
            pc_write_c = zero_flag;
            state_d    = ST_FETCH;
          end
          CLS_JUMP: begin
            pc_write_c = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        alu_sel_c = exec_alu_select(class_q);
        case (class_q)
          CLS_LOAD: begin
            mem_read_c = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end
          CLS_STORE: begin
            mem_write_c = 1'b1;
            if (mem_ready) state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_WB: begin
        alu_sel_c    = exec_alu_select(class_q);
        reg_write_c  = 1'b1;
        mem_to_reg_c = (class_q == CLS_LOAD);
        state_d      = ST_FETCH;
      end
      ST_HALT: halted_c = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset overrides outputs immediately, independent of clk.
  assign alu_select = rst ? ALU_SEL_RD2 : alu_sel_c;
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign ir_load    = ir_load_c    & ~rst;
  assign pc_write   = pc_write_c   & ~rst;
  assign reg_write  = reg_write_c  & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign halted     = halted_c     & ~rst;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected traces built from
// the instruction-class rules, checked cycle by cycle, plus reset checks.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero_flag = 1'b0;
  logic [1:0] alu_select;
  logic       mem_read, mem_write, ir_load, pc_write;
  logic       reg_write, mem_to_reg, halted, illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero_flag  (zero_flag),
    .alu_select (alu_select),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Observed outputs: alu, mr, mw, il, pw, rw, m2r, hlt, ill
  typedef struct packed {
    logic [1:0] alu;
    logic mr, mw, il, pw, rw, m2r, hlt, ill;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       z;
    exp_t       e;
    string      tag;
  } cyc_t;

  cyc_t q[$];
  exp_t act;
  assign act = {alu_select, mem_read, mem_write, ir_load, pc_write,
                reg_write, mem_to_reg, halted, illegal};

  localparam exp_t RESET_E   = 10'b10_0000_0000;
  localparam exp_t RELEASE_E = 10'b10_1000_0000;

  task automatic check(input string name, input exp_t got, input exp_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b required %b (alu,mr,mw,il,pw,rw,m2r,hlt,ill) t=%0t",
               name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic exp_t idle();
    exp_t e;
    e = '0;
    e.alu = 2'b10;
    return e;
  endfunction

  function automatic void push(input logic [5:0] op, input logic rdy, input logic z,
                               input exp_t e, input string tag);
    cyc_t c;
    c.op = op; c.rdy = rdy; c.z = z; c.e = e; c.tag = tag;
    q.push_back(c);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op <= 6'd5) || (op == 6'b111111);
  endfunction

  function automatic logic [1:0] class_alu(input logic [5:0] op);
    case (op)
      6'd1, 6'd5: return 2'b00;
      6'd2, 6'd3: return 2'b01;
      default:    return 2'b10;
    endcase
  endfunction

  // Expected trace of one instruction; returns its length in cycles.
  function automatic int add_instr(input logic [5:0] op, input logic z,
                                   input int fwait, input int mwait, input int hcyc);
    exp_t e;
    logic [5:0] junk;
    logic [1:0] alu;
    int n0;
    bit ld, st;
    n0 = q.size();
    junk = ~op;
    ld = (op == 6'd2);
    st = (op == 6'd3);
    for (int i = 0; i < fwait; i++) begin
      e = idle(); e.mr = 1'b1;
      push(junk, 1'b0, ~z, e, "fetch_wait");
    end
    e = idle(); e.mr = 1'b1; e.il = 1'b1; e.pw = 1'b1;
    push(junk, 1'b1, ~z, e, "fetch");
    push(op, 1'b1, ~z, idle(), "decode");
    if (op == 6'b111111 || !is_legal(op)) begin
      for (int i = 0; i < hcyc; i++) begin
        e = idle(); e.hlt = 1'b1; e.ill = !is_legal(op);
        push(junk, 1'(i % 2), 1'(i % 2), e, "halt");
      end
      return q.size() - n0;
    end
    alu = class_alu(op);
    e = idle(); e.alu = alu;
    if (op == 6'd4) e.pw = z;
    if (op == 6'd5) e.pw = 1'b1;
    push(junk, 1'b1, z, e, "exec");
    if (ld || st) begin
      for (int i = 0; i <= mwait; i++) begin
        e = idle(); e.alu = alu; e.mr = ld; e.mw = st;
        push(junk, 1'(i == mwait), ~z, e, "mem");
      end
    end
    if (op <= 6'd2) begin
      e = idle(); e.alu = alu; e.rw = 1'b1; e.m2r = ld;
      push(junk, 1'b1, ~z, e, "wb");
    end
    return q.size() - n0;
  endfunction

  // Drives each queued cycle at negedge and compares mid-cycle.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      opcode = c.op; mem_ready = c.rdy; zero_flag = c.z;
      #2;
      check(c.tag, act, c.e);
      tests++;
      if ((mem_read && mem_write) || (reg_write && mem_write)) begin
        fails++;
        $display("FAIL strobe_exclusive: got mr=%b mw=%b rw=%b required no overlap",
                 mem_read, mem_write, reg_write);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b111111;
    #2;
    check("reset_hold", act, RESET_E);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_release", act, RELEASE_E);
  endtask

  task automatic instr(input string name, input logic [5:0] op, input logic z,
                       input int fwait, input int mwait, input int lat);
    int n;
    n = add_instr(op, z, fwait, mwait, 0);
    check_int({name, "_latency"}, n, lat);
    run_queue();
  endtask

  initial begin
    int n;
    #2;
    check("reset_at_time0", act, RESET_E);
    do_reset();

    instr("r_alu",  6'b000000, 1'b0, 0, 0, 4);
    instr("i_alu",  6'b000001, 1'b0, 1, 0, 5);
    n = add_instr(6'b000010, 1'b0, 0, 2, 0);
    check_int("load_wait2_latency", n, 7);
    check("load_wb_pin", q[q.size()-1].e, 10'b01_0000_1100);
    run_queue();
    instr("store",  6'b000011, 1'b0, 0, 0, 4);
    n = add_instr(6'b000100, 1'b1, 0, 0, 0);
    check_int("beq_taken_latency", n, 3);
    check("beq_taken_exec_pin", q[2].e, 10'b10_0001_0000);
    run_queue();
    instr("beq_not_taken", 6'b000100, 1'b0, 0, 0, 3);
    instr("jump",   6'b000101, 1'b0, 0, 0, 3);
    instr("load",   6'b000010, 1'b1, 0, 0, 5);
    instr("store_wait1", 6'b000011, 1'b1, 2, 1, 7);

    // Illegal opcode halts and flags; strobes stay quiet.
    n = add_instr(6'b101010, 1'b0, 0, 0, 8);
    check_int("illegal_trace_len", n, 10);
    run_queue();
    do_reset();

    // Store aborted by reset while waiting in MEM.
    n = add_instr(6'b000011, 1'b0, 0, 2, 0);
    void'(q.pop_back());
    void'(q.pop_back());
    run_queue();
    #1 rst = 1'b1;
    #1 check("reset_mid_mem", act, RESET_E);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1 check("after_abort_fetch", act, RELEASE_E);

    // HALT opcode is absorbing for 20 cycles.
    n = add_instr(6'b111111, 1'b0, 0, 0, 20);
    check_int("halt_trace_len", n, 22);
    run_queue();
    do_reset();
    instr("r_alu_after_halt", 6'b000000, 1'b0, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  in  6  instr[31:26] from instruction register, valid from DECODE onward.
REQ-004 SHALL have port: mem_ready  in  1  memory completion strobe for the current fetch/load/store.
REQ-005 SHALL have port: zero_flag  in  1  ALU zero result, sampled in EXEC.
REQ-006 SHALL have port: alu_select  out  2  operand-2 source: 00 imm, 01 offset, 10 read_data_2.
REQ-007 SHALL have ports: mem_read, mem_write, ir_load, pc_write, reg_write, mem_to_reg  out  1 each.
REQ-008 SHALL have ports: halted, illegal  out  1 each  sticky status.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-010 SHALL decode the opcode classes: 000000 R-ALU, 000001 I-ALU, 000010 LOAD, 000011 STORE, 000100 BEQ, 000101 JUMP, 111111 HALT.
REQ-011 SHALL register the opcode class in DECODE; EXEC/MEM/WB outputs come from the registered class, not the live opcode.
REQ-012 FETCH: mem_read=1; on mem_ready=1 assert ir_load and pc_write for that cycle and go to DECODE; otherwise remain in FETCH.
REQ-013 DECODE: one cycle; legal class -> EXEC (HALT class -> HALT); illegal opcode -> HALT with illegal=1.
REQ-014 EXEC alu_select: R-ALU 10, I-ALU 00, LOAD/STORE 01, BEQ 10, JUMP 00.
REQ-015 EXEC next state: R-ALU/I-ALU -> WB; LOAD/STORE -> MEM; BEQ -> FETCH with pc_write=zero_flag; JUMP -> FETCH with pc_write=1.
REQ-016 MEM: LOAD drives mem_read=1, STORE drives mem_write=1; hold state and strobe until mem_ready=1; then LOAD -> WB, STORE -> FETCH.
REQ-017 WB: reg_write=1 for one cycle; mem_to_reg=1 only for LOAD; next state FETCH.
REQ-018 alu_select SHALL hold its EXEC value through MEM and WB; it SHALL be 10 in FETCH, DECODE and HALT.
REQ-019 mem_read and mem_write SHALL never be asserted together; reg_write and mem_write SHALL never be asserted together.
REQ-020 Latency in cycles with zero memory wait: R/I-ALU 4, LOAD 5, STORE 4, BEQ/JUMP 3; each mem_ready wait adds one cycle.
REQ-021 A mem_ready pulse outside FETCH or MEM SHALL be ignored.
REQ-022 HALT SHALL be absorbing: halted=1, all strobes 0, exited only by rst.

Reset
REQ-023 rst=1 SHALL immediately force state FETCH, class R-ALU, alu_select 10, all strobes 0, halted 0 and illegal 0, regardless of clk.
REQ-024 Reset asserted mid-MEM SHALL drop mem_read/mem_write in the same cycle; the aborted transaction is not retried.
REQ-025 After rst deasserts, the first rising edge SHALL evaluate FETCH, with mem_read=1 already driven during reset release.

Structure
REQ-026 Opcode constants, class enumeration, state enumeration and the alu_select encodings (00/01/10) SHALL live in a shared package, also used by the operand-2 mux.
REQ-027 Opcode-to-class decode SHALL be a separate combinational sub-module, op_class_decode; state register and output logic stay in control_fsm.
REQ-028 State encoding SHALL be binary, 3 bits; unused encodings recover to FETCH.

Verification
REQ-029 R-ALU opcode 000000, mem_ready high in FETCH -> states F,D,E,W over 4 cycles, alu_select=10 in E/W, reg_write pulse in W.
REQ-030 LOAD 000010, mem_ready held low 2 cycles in MEM -> mem_read held 3 MEM cycles, alu_select=01, WB with mem_to_reg=1, total 7 cycles.
REQ-031 BEQ 000100 with zero_flag=1 and then 0 -> pc_write=1 in EXEC only for the first; both return to FETCH after 3 cycles.
REQ-032 Opcode 101010 -> HALT after DECODE, illegal=1, halted=1; mem_ready toggling leaves all strobes at 0.
REQ-033 STORE 000011, rst asserted mid-MEM between clock edges -> mem_write drops asynchronously, FETCH after release, all status flags 0.
REQ-034 Opcode 111111 -> halted=1, illegal=0; stays in HALT for 20 cycles until rst.
